// File: rtl/a2d_spi_resp_if.sv
// rtl/a2d_spi_resp_if.sv - SPI link signals between the A2D master and the emulated converter
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder emulating the 8-channel 12-bit A2D converter (option: A2D_RESP_CMD_CHK_EN)
module a2d_spi_resp #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    a2d_spi_resp_if.slave         spi,
    input  logic [95:0]           chan_data,
    output logic                  cmd_vld,
    output logic [FRAME_BITS-1:0] last_cmd,
    output logic                  frm_err
`ifdef A2D_RESP_CMD_CHK_EN
    ,
    output logic                  cmd_bad
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchronizer chains: SYNC_STAGES flops plus one extra for edge detection
    logic [SYNC_STAGES:0] ss_pipe_q, ss_pipe_d;
    logic [SYNC_STAGES:0] sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_STAGES:0] mosi_pipe_q, mosi_pipe_d;

    logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
    logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] last_cmd_q, last_cmd_d;
    logic [2:0]            pend_chnl_q, pend_chnl_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic                  frm_err_q, frm_err_d;
`ifdef A2D_RESP_CMD_CHK_EN
    logic                  cmd_bad_q, cmd_bad_d;
    logic                  rx_bad;
`endif

    logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_sync;
    logic [11:0] chan_sel;

    // Shift each raw SPI input one stage deeper per clk; all chains share one depth to keep MOSI aligned with SCLK
    always_comb begin
        ss_pipe_d   = {ss_pipe_q[SYNC_STAGES-1:0],   spi.SS_n};
        sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], spi.SCLK};
        mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-1:0], spi.MOSI};
    end

    // Edge detection compares the last synchronized stage with the extra stage behind it
    always_comb begin
        ss_rise   =  ss_pipe_q[SYNC_STAGES-1]   & ~ss_pipe_q[SYNC_STAGES];
        ss_fall   = ~ss_pipe_q[SYNC_STAGES-1]   &  ss_pipe_q[SYNC_STAGES];
        sclk_rise =  sclk_pipe_q[SYNC_STAGES-1] & ~sclk_pipe_q[SYNC_STAGES];
        sclk_fall = ~sclk_pipe_q[SYNC_STAGES-1] &  sclk_pipe_q[SYNC_STAGES];
        mosi_sync =  mosi_pipe_q[SYNC_STAGES-1];
    end

    // Select the 12-bit value of the channel addressed by the previous complete frame
    always_comb begin
        chan_sel = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend_chnl_q == 3'(i)) begin
                chan_sel = chan_data[12*i +: 12];
            end
        end
    end

`ifdef A2D_RESP_CMD_CHK_EN
    // A command is malformed when any don't-care bit is set
    always_comb begin
        rx_bad = (|rx_shft_q[15:14]) | (|rx_shft_q[10:0]);
    end
`endif

    // Frame FSM: next state, shift registers, command capture and one-clk status pulses
    always_comb begin
        state_d     = state_q;
        tx_shft_d   = tx_shft_q;
        rx_shft_d   = rx_shft_q;
        bit_cnt_d   = bit_cnt_q;
        last_cmd_d  = last_cmd_q;
        pend_chnl_d = pend_chnl_q;
        cmd_vld_d   = 1'b0;
        frm_err_d   = 1'b0;
`ifdef A2D_RESP_CMD_CHK_EN
        cmd_bad_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_shft_d = {4'h0, chan_sel};
                rx_shft_d = '0;
                bit_cnt_d = '0;
                if (ss_rise) begin
                    frm_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // SS_n rise takes priority over any SCLK edge seen in the same clk
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == CNT_FULL) begin
                        last_cmd_d = rx_shft_q;
                        cmd_vld_d  = 1'b1;
`ifdef A2D_RESP_CMD_CHK_EN
                        cmd_bad_d  = rx_bad;
                        if (!rx_bad) begin
                            pend_chnl_d = rx_shft_q[13:11];
                        end
`else
                        pend_chnl_d = rx_shft_q[13:11];
`endif
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else if (sclk_rise && (bit_cnt_q != CNT_FULL)) begin
                    rx_shft_d = {rx_shft_q[FRAME_BITS-2:0], mosi_sync};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL)) begin
                    // First fall after LOAD is skipped so the MSB is still present at the first rise
                    tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; SS_n and SCLK chains reset to their idle-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_pipe_q   <= '1;
            sclk_pipe_q <= '1;
            mosi_pipe_q <= '0;
            tx_shft_q   <= '0;
            rx_shft_q   <= '0;
            bit_cnt_q   <= '0;
            last_cmd_q  <= '0;
            pend_chnl_q <= '0;
            cmd_vld_q   <= 1'b0;
            frm_err_q   <= 1'b0;
`ifdef A2D_RESP_CMD_CHK_EN
            cmd_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ss_pipe_q   <= ss_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            last_cmd_q  <= last_cmd_d;
            pend_chnl_q <= pend_chnl_d;
            cmd_vld_q   <= cmd_vld_d;
            frm_err_q   <= frm_err_d;
`ifdef A2D_RESP_CMD_CHK_EN
            cmd_bad_q   <= cmd_bad_d;
`endif
        end
    end

    assign spi.MISO = (state_q == IDLE) ? 1'b0 : tx_shft_q[FRAME_BITS-1];
    assign cmd_vld  = cmd_vld_q;
    assign frm_err  = frm_err_q;
    assign last_cmd = last_cmd_q;
`ifdef A2D_RESP_CMD_CHK_EN
    assign cmd_bad  = cmd_bad_q;
`endif

endmodule
